// File: rtl/io_bus_master.sv
// CPU-side initiator for the peripheral IO bus: one access at a time, slot decode, ready/timeout handling.
// Optional error capture register enabled with `define IO_BUS_ERR_LOG_EN.
module io_bus_master #(
    parameter logic [7:0] DEV_PRESENT    = 8'b0000_0011,
    parameter int         TIMEOUT_CYCLES = 15,
    parameter int         DATA_W         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_wr,
    input  logic [6:0]          cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wr_data,
    output logic                cpu_ack,
    output logic                cpu_err,
    output logic [DATA_W-1:0]   cpu_rd_data,
    output logic [7:0]          dev_sel,
    output logic [3:0]          io_addr,
    output logic                io_rd,
    output logic                io_wr,
    output logic [DATA_W-1:0]   io_wr_data,
    input  logic [8*DATA_W-1:0] dev_rd_data,
`ifdef IO_BUS_ERR_LOG_EN
    output logic                err_valid,
    output logic [8:0]          err_info,
    input  logic                err_clr,
`endif
    input  logic [7:0]          dev_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_ERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] slot_q;

    // io_addr / io_rd / io_wr double as the latched request while in ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            slot_q      <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rd_data <= '0;
            dev_sel     <= '0;
            io_addr     <= '0;
            io_rd       <= 1'b0;
            io_wr       <= 1'b0;
            io_wr_data  <= '0;
`ifdef IO_BUS_ERR_LOG_EN
            err_valid   <= 1'b0;
            err_info    <= '0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
`ifdef IO_BUS_ERR_LOG_EN
            if (err_clr) err_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        slot_q <= cpu_addr[6:4];
                        if (DEV_PRESENT[cpu_addr[6:4]]) begin
                            state      <= ST_ACCESS;
                            cnt        <= '0;
                            dev_sel    <= 8'b1 << cpu_addr[6:4];
                            io_addr    <= cpu_addr[3:0];
                            io_wr_data <= cpu_wr_data;
                            io_rd      <= ~cpu_wr;
                            io_wr      <= cpu_wr;
                        end else begin
                            state       <= ST_ERR;
                            cpu_ack     <= 1'b1;
                            cpu_err     <= 1'b1;
                            cpu_rd_data <= '0;
`ifdef IO_BUS_ERR_LOG_EN
                            err_valid   <= 1'b1;
                            err_info    <= {1'b0, cpu_wr, cpu_addr};
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 8'd1;
                    // ready is checked first so it beats a coincident timeout
                    if (dev_ready[slot_q]) begin
                        if (io_rd) cpu_rd_data <= dev_rd_data[slot_q*DATA_W +: DATA_W];
                        state      <= ST_DONE;
                        cpu_ack    <= 1'b1;
                        dev_sel    <= '0;
                        io_addr    <= '0;
                        io_rd      <= 1'b0;
                        io_wr      <= 1'b0;
                        io_wr_data <= '0;
                    end else if (cnt == TO_LAST) begin
                        state       <= ST_ERR;
                        cpu_ack     <= 1'b1;
                        cpu_err     <= 1'b1;
                        cpu_rd_data <= '0;
                        dev_sel     <= '0;
                        io_addr     <= '0;
                        io_rd       <= 1'b0;
                        io_wr       <= 1'b0;
                        io_wr_data  <= '0;
`ifdef IO_BUS_ERR_LOG_EN
                        err_valid   <= 1'b1;
                        err_info    <= {1'b1, io_wr, slot_q, io_addr};
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed plan steps plus randomized accesses against a cycle-count reference model.
module tb_io_bus_master;
    localparam int         DW   = 32;
    localparam int         TO   = 15;
    localparam logic [7:0] PRES = 8'b0000_0011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cpu_req = 1'b0;
    logic            cpu_wr = 1'b0;
    logic [6:0]      cpu_addr = '0;
    logic [DW-1:0]   cpu_wr_data = '0;
    logic            cpu_ack, cpu_err;
    logic [DW-1:0]   cpu_rd_data;
    logic [7:0]      dev_sel;
    logic [3:0]      io_addr;
    logic            io_rd, io_wr;
    logic [DW-1:0]   io_wr_data;
    logic [8*DW-1:0] dev_rd_data = '0;
    logic [7:0]      dev_ready = '0;
`ifdef IO_BUS_ERR_LOG_EN
    logic            err_valid;
    logic [8:0]      err_info;
    logic            err_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_rd = '0;

    io_bus_master #(.DEV_PRESENT(PRES), .TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rd_data(cpu_rd_data),
        .dev_sel(dev_sel), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_wr_data(io_wr_data),
        .dev_rd_data(dev_rd_data),
`ifdef IO_BUS_ERR_LOG_EN
        .err_valid(err_valid), .err_info(err_info), .err_clr(err_clr),
`endif
        .dev_ready(dev_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access. d = ready delay: selected slot's ready goes high in ACCESS cycle d+1.
    task automatic xact(input logic wr, input logic [6:0] addr, input logic [DW-1:0] wdata,
                        input int d, input bit noise);
        logic [2:0]    slot;
        logic [DW-1:0] word;
        bit            present, exp_err, bad, got;
        int            exp_ack, exp_acc, k, acc_cnt;
        slot    = addr[6:4];
        present = PRES[slot];
        for (int s = 0; s < 8; s++) dev_rd_data[s*DW +: DW] = $urandom;
        word = dev_rd_data[slot*DW +: DW];
        if (!present) begin
            exp_ack = 1; exp_acc = 0; exp_err = 1'b1;
        end else if (d < TO) begin
            exp_ack = d + 2; exp_acc = d + 1; exp_err = 1'b0;
        end else begin
            exp_ack = TO + 1; exp_acc = TO; exp_err = 1'b1;
        end
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wr_data = wdata; dev_ready = '0;
        k = 0; acc_cnt = 0; bad = 1'b0; got = 1'b0;
        while (!got && k < TO + 8) begin
            @(posedge clk); @(negedge clk); k++;
            // request fields change after acceptance; the access in flight must not care
            cpu_addr = 7'($urandom); cpu_wr = 1'($urandom); cpu_wr_data = $urandom;
            if (io_rd || io_wr || dev_sel != 8'h00) begin
                acc_cnt++;
                if (dev_sel !== (8'b1 << slot) || io_rd !== ~wr || io_wr !== wr ||
                    io_addr !== addr[3:0] || io_wr_data !== wdata) bad = 1'b1;
            end
            dev_ready = noise ? 8'($urandom) : 8'h00;
            dev_ready[slot] = present && (k >= d + 1);
            if (cpu_ack === 1'b1) begin
                got = 1'b1;
                cpu_req = 1'b0;
                check("ack_cycle", 64'(k), 64'(exp_ack));
                check("ack_err", {63'd0, cpu_err}, {63'd0, exp_err});
                check("access_cycles", 64'(acc_cnt), 64'(exp_acc));
                check("bus_signals_bad", {63'd0, bad}, 64'd0);
            end
        end
        if (!got) begin
            check("ack_seen", 64'd0, 64'd1);
            cpu_req = 1'b0;
        end
        if (exp_err) exp_rd = '0;
        else if (!wr) exp_rd = word;
        check("rd_data", 64'(cpu_rd_data), 64'(exp_rd));
`ifdef IO_BUS_ERR_LOG_EN
        if (exp_err) begin
            check("err_valid", {63'd0, err_valid}, 64'd1);
            check("err_info", 64'(err_info), 64'({present, wr, addr}));
        end
`endif
        dev_ready = '0;
        @(negedge clk);
        check("ack_one_cycle", {63'd0, cpu_ack}, 64'd0);
    endtask

    initial begin
        #12;
        check("rst_outputs", {cpu_ack, cpu_err, io_rd, io_wr, dev_sel, io_addr}, '0);
        check("rst_data", {cpu_rd_data, io_wr_data}, '0);
`ifdef IO_BUS_ERR_LOG_EN
        check("rst_errlog", {err_valid, err_info}, '0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        xact(1'b1, 7'h10, 32'h0000_00A5, 2, 1'b0);   // write LEDC, ready after 2 cycles
        xact(1'b0, 7'h01, 32'h0, 0, 1'b0);           // read INR, ready immediate
        xact(1'b0, 7'h53, 32'h0, 0, 1'b1);           // absent slot 5
`ifdef IO_BUS_ERR_LOG_EN
        err_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        err_clr = 1'b0;
        check("err_clr_valid", {63'd0, err_valid}, 64'd0);
        check("err_clr_info", 64'(err_info), 64'h053);
`endif
        xact(1'b0, 7'h13, 32'h0, 1000, 1'b1);        // timeout on KEYS
        xact(1'b0, 7'h13, 32'h0, TO - 1, 1'b0);      // ready on the last ACCESS cycle

        // async reset in the second ACCESS cycle
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 7'h13; dev_ready = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre_rst_sel", 64'(dev_sel), 64'h02);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_bus", {cpu_ack, cpu_err, io_rd, io_wr, dev_sel}, '0);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_ack_in_rst", {63'd0, cpu_ack}, 64'd0);
        end
        rst_n = 1'b1;
        exp_rd = '0;
        @(negedge clk);
        check("no_ack_after_rst", {63'd0, cpu_ack}, 64'd0);
        xact(1'b1, 7'h11, 32'h1234_5678, 1, 1'b1);   // write SSDC after reset

        for (int n = 0; n < 24; n++) begin
            logic [6:0] a;
            a = {3'($urandom_range(0, 3)), 4'($urandom)};
            xact(1'($urandom), a, $urandom, $urandom_range(0, TO + 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
